// File: rtl/axis_width_split.sv
`default_nettype none
// ============================================================================
//  Module   : axis_width_split
//  Purpose  : AXI-stream width down-converter. Each accepted wide word is
//             replayed as RATIO narrow beats; tlast rides on the final beat.
//  Revision : 1.0  initial release
// ============================================================================
module axis_width_split #(
    parameter int DATA_WIDTH_IN  = 256,
    parameter int DATA_WIDTH_OUT = 32,
    parameter bit MSB_FIRST      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH_IN-1:0]  s_axis_tdata,
    input  logic                      s_axis_tlast,

    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH_OUT-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,

    output logic                      busy
);

    localparam int RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [CW-1:0] c_last_idx = CW'(RATIO - 1);
    localparam logic [CW-1:0] c_one      = CW'(1);

    generate
        if ((DATA_WIDTH_IN % DATA_WIDTH_OUT) != 0) begin : g_bad_width
            $fatal(1, "axis_width_split: DATA_WIDTH_IN must be a multiple of DATA_WIDTH_OUT");
        end
        if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
            $fatal(1, "axis_width_split: RATIO must be a power of two and at least 2");
        end
    endgenerate

    // r_valid doubles as the state: 0 = EMPTY, 1 = HOLD
    logic [DATA_WIDTH_IN-1:0] r_word;
    logic                     r_last;
    logic                     r_valid;
    logic [CW-1:0]            r_idx;

    logic                      w_last_beat;
    logic                      w_accept;
    logic [CW-1:0]             w_k;
    logic [DATA_WIDTH_OUT-1:0] w_slice [RATIO];

    assign w_last_beat   = (r_idx == c_last_idx);
    assign s_axis_tready = ~r_valid | (m_axis_tready & w_last_beat);
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            // covers both the EMPTY load and the no-bubble reload on the last beat
            r_word  <= s_axis_tdata;
            r_last  <= s_axis_tlast;
            r_valid <= 1'b1;
            r_idx   <= '0;
        end else if (r_valid && m_axis_tready) begin
            if (w_last_beat) begin
                r_valid <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + c_one;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
            assign w_slice[gi] = r_word[gi*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
        end

        if (MSB_FIRST) begin : g_msb_first
            assign w_k = c_last_idx - r_idx;
        end else begin : g_lsb_first
            assign w_k = r_idx;
        end
    endgenerate

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = w_slice[w_k];
    assign m_axis_tlast  = r_valid & r_last & w_last_beat;
    assign busy          = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_axis_width_split.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_width_split
//  Purpose  : Directed vector table plus a randomised scoreboard run for
//             axis_width_split, LSB-first and MSB-first instances side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_width_split;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [255:0] s_data;
    logic         s_last;
    logic         m_ready;

    logic         s_ready_l, m_valid_l, m_last_l, busy_l;
    logic [31:0]  m_data_l;
    logic         s_ready_m, m_valid_m, m_last_m, busy_m;
    logic [31:0]  m_data_m;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    axis_width_split #(.DATA_WIDTH_IN(256), .DATA_WIDTH_OUT(32), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_l), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid_l), .m_axis_tready(m_ready), .m_axis_tdata(m_data_l), .m_axis_tlast(m_last_l),
        .busy(busy_l)
    );

    axis_width_split #(.DATA_WIDTH_IN(256), .DATA_WIDTH_OUT(32), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_m), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid_m), .m_axis_tready(m_ready), .m_axis_tdata(m_data_m), .m_axis_tlast(m_last_m),
        .busy(busy_m)
    );

    typedef struct {
        logic         rst;
        logic         sv;
        logic [255:0] sd;
        logic         sl;
        logic         mr;
        logic         chk;
        logic         chk_d;
        logic         ev;
        logic [31:0]  ed;
        logic [31:0]  edm;
        logic         el;
        logic         er;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mkbeat(input int tag, input int j);
        return 32'((tag << 8) | j);
    endfunction

    function automatic logic [255:0] mkword(input int tag);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = mkbeat(tag, j);
        return w;
    endfunction

    function automatic void row(input logic r, input logic sv, input logic [255:0] sd, input logic sl,
                                input logic mr, input logic ck, input logic ckd, input logic ev,
                                input logic [31:0] ed, input logic [31:0] edm, input logic el, input logic er);
        vec_t v;
        v.rst = r; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.chk = ck; v.chk_d = ckd; v.ev = ev; v.ed = ed; v.edm = edm; v.el = el; v.er = er;
        vecs.push_back(v);
    endfunction

    // a held word's beat j: LSB-first shows slice j, MSB-first shows slice 7-j
    function automatic void beat_row(input int tag, input int j, input logic mr, input logic is_tlast_word,
                                     input logic sv, input logic [255:0] sd, input logic sl);
        row(1'b0, sv, sd, sl, mr, 1'b1, 1'b1, 1'b1, mkbeat(tag, j), mkbeat(tag, 7 - j),
            is_tlast_word && (j == 7), mr && (j == 7));
    endfunction

    function automatic void idle_row();
        row(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endfunction

    function automatic void build_table();
        row(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        row(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        // post-reset state checked while presenting the first word
        row(1'b0, 1'b1, mkword(0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) beat_row(0, j, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle_row();

        // four back-to-back words, tlast only on the fourth
        row(1'b0, 1'b1, mkword(1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int w = 1; w <= 4; w++) begin
            for (int j = 0; j < 8; j++) begin
                if (j == 7 && w < 4) beat_row(w, j, 1'b1, w == 4, 1'b1, mkword(w + 1), (w + 1) == 4);
                else                 beat_row(w, j, 1'b1, w == 4, 1'b0, '0, 1'b0);
            end
        end
        idle_row();

        // backpressure: each beat first stalled, then taken; word 6 waits while stalled
        row(1'b0, 1'b1, mkword(5), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            beat_row(5, j, 1'b0, 1'b1, j == 7, (j == 7) ? mkword(6) : '0, 1'b0);
            beat_row(5, j, 1'b1, 1'b1, j == 7, (j == 7) ? mkword(6) : '0, 1'b0);
        end
        for (int j = 0; j < 8; j++) beat_row(6, j, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle_row();

        // reset after beat 3 of word 7: word 8 must start cleanly at beat 0
        row(1'b0, 1'b1, mkword(7), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) beat_row(7, j, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        row(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, mkbeat(7, 4), mkbeat(7, 3), 1'b0, 1'b0);
        row(1'b0, 1'b1, mkword(8), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) beat_row(8, j, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle_row();
    endfunction

    initial begin
        logic [32:0] lsbq[$];
        logic [32:0] msbq[$];
        logic [32:0] e;
        logic        accepted;
        logic        prev_stall;
        logic [31:0] prev_dl, prev_dm;
        logic        prev_ll, prev_lm;
        int          sent, tin, tout, cyc;
        localparam int NWORDS = 1000;

        build_table();

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; s_valid = vecs[i].sv; s_data = vecs[i].sd;
            s_last = vecs[i].sl; m_ready = vecs[i].mr;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("row%0d_valid", i), 256'(m_valid_l), 256'(vecs[i].ev));
                check($sformatf("row%0d_last", i), 256'(m_last_l), 256'(vecs[i].el));
                check($sformatf("row%0d_last_msb", i), 256'(m_last_m), 256'(vecs[i].el));
                check($sformatf("row%0d_s_ready", i), 256'(s_ready_l), 256'(vecs[i].er));
                check($sformatf("row%0d_busy", i), 256'(busy_l), 256'(vecs[i].ev));
                if (vecs[i].chk_d) begin
                    check($sformatf("row%0d_data", i), 256'(m_data_l), 256'(vecs[i].ed));
                    check($sformatf("row%0d_data_msb", i), 256'(m_data_m), 256'(vecs[i].edm));
                end
            end
            @(posedge clk);
            #1;
        end

        // randomised traffic against a reference split
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        sent = 0; tin = 0; tout = 0; cyc = 0; prev_stall = 1'b0;
        prev_dl = '0; prev_dm = '0; prev_ll = 1'b0; prev_lm = 1'b0;
        while ((sent < NWORDS || lsbq.size() > 0) && cyc < 60000) begin
            if (!s_valid && sent < NWORDS && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                s_last  = 1'($urandom_range(0, 1));
            end
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall) begin
                check("rnd_stall_valid", 256'(m_valid_l), 256'(1));
                check("rnd_stall_data", 256'(m_data_l), 256'(prev_dl));
                check("rnd_stall_data_msb", 256'(m_data_m), 256'(prev_dm));
                check("rnd_stall_last", 256'(m_last_l), 256'(prev_ll));
                check("rnd_stall_last_msb", 256'(m_last_m), 256'(prev_lm));
            end
            if (m_valid_l && m_ready) begin
                if (lsbq.size() == 0) begin
                    checks++;
                    $display("FAIL rnd_extra_beat: got beat %h expected no beat", m_data_l);
                end else begin
                    e = lsbq.pop_front();
                    check("rnd_lsb", 256'({m_last_l, m_data_l}), 256'(e));
                    e = msbq.pop_front();
                    check("rnd_msb", 256'({m_last_m, m_data_m}), 256'(e));
                end
                if (m_last_l) tout++;
            end
            accepted = s_valid && s_ready_l;
            if (accepted) begin
                for (int j = 0; j < 8; j++) begin
                    lsbq.push_back({s_last && (j == 7), s_data[j*32 +: 32]});
                    msbq.push_back({s_last && (j == 7), s_data[(7 - j)*32 +: 32]});
                end
                if (s_last) tin++;
                sent++;
            end
            prev_stall = m_valid_l && !m_ready;
            prev_dl = m_data_l; prev_dm = m_data_m;
            prev_ll = m_last_l; prev_lm = m_last_m;
            @(posedge clk);
            #1;
            if (accepted) s_valid = 1'b0;
            cyc++;
        end
        check("rnd_words_sent", 256'(sent), 256'(NWORDS));
        check("rnd_drained", 256'(lsbq.size()), 256'(0));
        check("rnd_tlast_count", 256'(tout), 256'(tin));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_width_split.md
Name: axis_width_split

Overview:
AXI-stream width down-converter that serializes each wide input word into RATIO narrower output beats in a single clock domain. It sits directly downstream of the wide-word asynchronous clock-converter FIFO. It takes 256-bit words on the destination clock and emits 32-bit beats to the downstream sample-processing chain. Frame boundaries (tlast) are preserved on the final sub-beat of each word.

Parameters:
DATA_WIDTH_IN, 256, input word width in bits.
DATA_WIDTH_OUT, 32, output beat width in bits.
MSB_FIRST, 0, beat order within a word: 0 = bits [W-1:0] first, 1 = most-significant slice first.
RATIO (derived), DATA_WIDTH_IN/DATA_WIDTH_OUT.
CW (derived), clog2(RATIO), beat-index counter width.

Ports:
clk  input  1  block clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
s_axis_tvalid  input  1  input word valid.
s_axis_tready  output  1  input word accepted when high with tvalid.
s_axis_tdata  input  DATA_WIDTH_IN  input word.
s_axis_tlast  input  1  input word ends a frame.
m_axis_tvalid  output  1  output beat valid.
m_axis_tready  input  1  downstream ready.
m_axis_tdata  output  DATA_WIDTH_OUT  output beat.
m_axis_tlast  output  1  frame end, asserted only on the last beat of a tlast word.
busy  output  1  high while a word is held (equals m_axis_tvalid).

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Elaboration checks:
  - DATA_WIDTH_IN % DATA_WIDTH_OUT == 0.
  - RATIO >= 2 and a power of two.
  - A violation is a fatal elaboration error.
- State:
  - word_q (DATA_WIDTH_IN), last_q (1), valid_q (1), idx_q (CW bits).
  - Two states, implied by valid_q: EMPTY (valid_q=0) and HOLD (valid_q=1).
- Reset (rst=1 at clock edge):
  - valid_q=0, idx_q=0, last_q=0, word_q=0.
  - Outputs during and after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - s_axis_tready=1 in the cycle after reset deasserts.
- Reset mid-word: the held word and its remaining beats are discarded; no partial beats are emitted afterwards.
- Output mapping:
  - m_axis_tvalid = valid_q.
  - m_axis_tdata = slice k of word_q.
    - k = idx_q when MSB_FIRST=0.
    - k = RATIO-1-idx_q when MSB_FIRST=1.
    - Slice k = word_q[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT].
  - m_axis_tlast = valid_q & last_q & (idx_q == RATIO-1).
  - Outputs are driven only from flops plus the slice mux; there is no combinational path from s_axis_* to m_axis_*.
- Ready: s_axis_tready = ~valid_q | (m_axis_tready & idx_q == RATIO-1).
  - This is the only combinational input-side path, from m_axis_tready.
- EMPTY state:
  - When s_axis_tvalid=1, load word_q and last_q, set valid_q=1, idx_q=0 and go to HOLD.
  - Latency is 1 cycle: the first beat is valid in the cycle after acceptance.
- HOLD state, on m_axis_tready=1:
  - If idx_q < RATIO-1: idx_q increments.
  - If idx_q == RATIO-1 and s_axis_tvalid=1: load the new word, idx_q=0, stay in HOLD. This gives back-to-back words with no bubble.
  - If idx_q == RATIO-1 and s_axis_tvalid=0: valid_q=0, idx_q=0, go to EMPTY.
- HOLD state, on m_axis_tready=0:
  - All state holds.
  - m_axis_tdata, m_axis_tlast and m_axis_tvalid stay stable (AXIS rule).
- Throughput: 1 output beat per cycle sustained under continuous input and ready.
- A word with s_axis_tlast=0 never produces m_axis_tlast.
- A tlast word produces exactly one m_axis_tlast, on beat RATIO-1.
- s_axis_tvalid without acceptance has no effect.
- The block never drops or duplicates a beat.

Test Plan:
- Single word 0x00000007_00000006_..._00000000, tlast=1, ready=1, MSB_FIRST=0 -> 8 beats 0,1,...,7 on consecutive cycles starting 1 cycle after acceptance; m_axis_tlast only on beat 7; tready low during beats 0-6.
- Same word with MSB_FIRST=1 -> beats 7,6,...,0; tlast on the beat carrying 0.
- 4 back-to-back words (tlast on word 3), ready=1 -> 32 consecutive beats with no gap; tready=1 exactly on the last-beat cycles; a single tlast at beat 31.
- Random m_axis_tready (50%) over 1000 random words, scoreboard vs reference split -> all beats match in order; tdata/tlast stable while valid & ~ready; tlast count equals input tlast count.
- Assert rst for 1 cycle after beat 3 of a word -> next cycle m_axis_tvalid=0, tdata=0, busy=0; next accepted word starts again at beat 0; the old beats never appear.
- Input idle after one word -> tvalid drops the cycle after beat 7 is taken; tready=1 in EMPTY; a word presented then is accepted in 1 cycle.
